// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched: SHA-256 message-schedule sequencer.
// Loads one 512-bit block as 16 words, then streams W0..W63. For t>=16 the
// sigma functions come from a shared hash-function unit (op 6 = sigma0,
// op 7 = sigma1), so each word takes three cycles.
// Optional macro SCHED_INTERNAL_SIGMA_EN: sigma0/sigma1 are computed locally,
// the external unit is left idle and the block streams one word per cycle.
module sha256_msg_sched (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [5:0]  out_index,
   output logic        out_last,
   output logic [2:0]  hfnc_op,
   output logic [31:0] hfnc_x,
   input  logic [31:0] hfnc_result
);

   typedef enum logic [2:0] {S_LOAD, S_DIRECT, S_SIG0, S_SIG1, S_OUT} state_t;

   state_t      state_q;
   logic [31:0] wbuf_q [16];
   logic [3:0]  k_q;
   logic [5:0]  t_q;
   logic        in_ready_q;
   logic        out_valid_q;
   logic        out_last_q;
   logic [31:0] out_data_q;
   logic [5:0]  out_index_q;
   logic [2:0]  hfnc_op_q;
   logic [31:0] hfnc_x_q;

   logic        load_hs;
   logic        out_hs;
   logic [3:0]  nt;
   logic        wr_en_d;
   logic [3:0]  wr_addr_d;
   logic [31:0] wr_data_d;

   assign load_hs = (state_q == S_LOAD) && in_valid;
   assign out_hs  = out_valid_q && out_ready;
   assign nt      = t_q[3:0] + 4'd1;

`ifdef SCHED_INTERNAL_SIGMA_EN
   logic [3:0]  n1, n9, n14;
   logic [31:0] next_w;
   logic        unused_hfnc;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] sig0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sig1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   // Slots of W[t+1-15], W[t+1-7], W[t+1-2]; W[t+1-16] sits at nt itself.
   assign n1  = nt + 4'd1;
   assign n9  = nt + 4'd9;
   assign n14 = nt + 4'd14;
   assign next_w = sig1(wbuf_q[n14]) + wbuf_q[n9] + sig0(wbuf_q[n1]) + wbuf_q[nt];
   assign unused_hfnc = ^hfnc_result;
`else
   localparam logic [2:0] OP_SIG0 = 3'd6;
   localparam logic [2:0] OP_SIG1 = 3'd7;

   logic [3:0]  i2, i9, i14;
   logic [31:0] s0_q;
   logic [31:0] sum;

   // i2: W[t+1-15] for the next step; i14/i9: W[t-2]/W[t-7] for this step.
   assign i2  = t_q[3:0] + 4'd2;
   assign i9  = t_q[3:0] + 4'd9;
   assign i14 = t_q[3:0] + 4'd14;
   assign sum = hfnc_result + wbuf_q[i9] + s0_q + wbuf_q[t_q[3:0]];
`endif

   // Select the single buffer write of this cycle: a loaded word or a new Wt.
   always_comb begin
      wr_en_d   = load_hs;
      wr_addr_d = k_q;
      wr_data_d = in_data;
`ifdef SCHED_INTERNAL_SIGMA_EN
      if (state_q == S_DIRECT && out_hs && t_q >= 6'd15 && t_q != 6'd63) begin
         wr_en_d   = 1'b1;
         wr_addr_d = nt;
         wr_data_d = next_w;
      end
`else
      if (state_q == S_SIG1) begin
         wr_en_d   = 1'b1;
         wr_addr_d = t_q[3:0];
         wr_data_d = sum;
      end
`endif
   end

   // Circular word buffer; W[t] lives in slot t mod 16, no reset needed.
   always_ff @(posedge clk) begin
      if (wr_en_d) wbuf_q[wr_addr_d] <= wr_data_d;
   end

   // Sequencer FSM with all handshake and hash-unit outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_LOAD;
         k_q         <= 4'd0;
         t_q         <= 6'd0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_data_q  <= 32'd0;
         out_index_q <= 6'd0;
         out_last_q  <= 1'b0;
         hfnc_op_q   <= 3'd0;
         hfnc_x_q    <= 32'd0;
`ifndef SCHED_INTERNAL_SIGMA_EN
         s0_q        <= 32'd0;
`endif
      end else begin
         case (state_q)
            S_LOAD: begin
               if (in_valid) begin
                  k_q <= k_q + 4'd1;
                  if (k_q == 4'd15) begin
                     state_q     <= S_DIRECT;
                     in_ready_q  <= 1'b0;
                     out_valid_q <= 1'b1;
                     out_data_q  <= wbuf_q[0];
                     out_index_q <= 6'd0;
                     out_last_q  <= 1'b0;
                     t_q         <= 6'd0;
                  end
               end
            end
`ifdef SCHED_INTERNAL_SIGMA_EN
            S_DIRECT: begin
               if (out_hs) begin
                  if (t_q == 6'd63) begin
                     state_q     <= S_LOAD;
                     in_ready_q  <= 1'b1;
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                     t_q         <= 6'd0;
                  end else begin
                     t_q         <= t_q + 6'd1;
                     out_index_q <= t_q + 6'd1;
                     out_last_q  <= (t_q == 6'd62);
                     out_data_q  <= (t_q < 6'd15) ? wbuf_q[nt] : next_w;
                  end
               end
            end
`else
            S_DIRECT: begin
               if (out_hs) begin
                  if (t_q == 6'd15) begin
                     state_q     <= S_SIG0;
                     out_valid_q <= 1'b0;
                     t_q         <= 6'd16;
                     hfnc_op_q   <= OP_SIG0;
                     hfnc_x_q    <= wbuf_q[i2];
                  end else begin
                     t_q         <= t_q + 6'd1;
                     out_index_q <= t_q + 6'd1;
                     out_data_q  <= wbuf_q[nt];
                  end
               end
            end
            S_SIG0: begin
               s0_q      <= hfnc_result;
               hfnc_op_q <= OP_SIG1;
               hfnc_x_q  <= wbuf_q[i14];
               state_q   <= S_SIG1;
            end
            S_SIG1: begin
               out_data_q  <= sum;
               out_valid_q <= 1'b1;
               out_index_q <= t_q;
               out_last_q  <= (t_q == 6'd63);
               hfnc_op_q   <= 3'd0;
               hfnc_x_q    <= 32'd0;
               state_q     <= S_OUT;
            end
            S_OUT: begin
               if (out_hs) begin
                  out_valid_q <= 1'b0;
                  if (t_q == 6'd63) begin
                     state_q    <= S_LOAD;
                     in_ready_q <= 1'b1;
                     out_last_q <= 1'b0;
                     t_q        <= 6'd0;
                  end else begin
                     t_q       <= t_q + 6'd1;
                     state_q   <= S_SIG0;
                     hfnc_op_q <= OP_SIG0;
                     hfnc_x_q  <= wbuf_q[i2];
                  end
               end
            end
`endif
            default: state_q <= S_LOAD;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_index = out_index_q;
   assign out_last  = out_last_q;
   assign hfnc_op   = hfnc_op_q;
   assign hfnc_x    = hfnc_x_q;

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Testbench for sha256_msg_sched: random and known blocks against a
// behavioural SHA-256 schedule model; also models the shared hash unit.
`timescale 1ns/1ps
module tb_sha256_msg_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [5:0]  out_index;
   logic        out_last;
   logic [2:0]  hfnc_op;
   logic [31:0] hfnc_x;
   logic [31:0] hfnc_result;

`ifdef SCHED_INTERNAL_SIGMA_EN
   localparam int PER = 1;
   localparam bit EXT = 1'b0;
`else
   localparam int PER = 3;
   localparam bit EXT = 1'b1;
`endif
   localparam int TRACE_N = 1024;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] msg [16];
   logic [31:0] exp_w [64];
   logic [31:0] got [64];
   int          hs_cyc [64];
   int          rise_cyc [64];
   logic [2:0]  op_tr [TRACE_N];
   logic [31:0] x_tr [TRACE_N];
   int n_got, last_cnt, last_bad, idx_bad, stall_moved, stall_hf, stall_seen;

   always #5 clk = ~clk;

   sha256_msg_sched dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_index(out_index), .out_last(out_last),
      .hfnc_op(hfnc_op), .hfnc_x(hfnc_x), .hfnc_result(hfnc_result)
   );

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction
   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction
   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   // Shared hash-function unit with Y/Z tied to zero.
   assign hfnc_result = (hfnc_op == 3'd6) ? ssig0(hfnc_x) :
                        (hfnc_op == 3'd7) ? ssig1(hfnc_x) : 32'd0;

   task automatic make_ref();
      for (int t = 0; t < 64; t++) begin
         if (t < 16) exp_w[t] = msg[t];
         else exp_w[t] = ssig1(exp_w[t-2]) + exp_w[t-7] + ssig0(exp_w[t-15]) + exp_w[t-16];
      end
   endtask

   task automatic rand_msg();
      for (int i = 0; i < 16; i++) msg[i] = $urandom;
      make_ref();
   endtask

   task automatic load_block(input bit gaps);
      int k = 0;
      int guard = 0;
      bit rdy;
      while (k < 16 && guard < 100) begin
         @(negedge clk);
         guard++;
         rdy = in_ready;
         if (gaps && (guard % 2 == 0)) begin
            in_valid = 1'b0;
            in_data  = $urandom;
         end else begin
            in_valid = 1'b1;
            in_data  = msg[k];
         end
         @(posedge clk);
         if (rdy && in_valid) k++;
      end
      vectors++;
      if (k != 16) begin
         miscompares++;
         $display("FAIL load_words: accepted %0d, required 16", k);
      end
   endtask

   task automatic collect(input int stall_t, input int stall_len, input bit pulse, input int abort_t);
      int cyc = 0;
      int stall_cnt = 0;
      logic [31:0] snap_d = 32'd0;
      n_got = 0; last_cnt = 0; last_bad = 0; idx_bad = 0;
      stall_moved = 0; stall_hf = 0; stall_seen = 0;
      for (int i = 0; i < 64; i++) begin
         rise_cyc[i] = -1;
         hs_cyc[i]   = -1;
      end
      while (n_got < 64 && cyc < TRACE_N - 1) begin
         @(negedge clk);
         cyc++;
         op_tr[cyc] = hfnc_op;
         x_tr[cyc]  = hfnc_x;
         in_valid = pulse ? 1'($urandom_range(0, 1)) : 1'b0;
         in_data  = $urandom;
         if (abort_t >= 0 && out_valid && out_index == 6'(abort_t)) break;
         if (out_valid && rise_cyc[out_index] < 0) rise_cyc[out_index] = cyc;
         if (stall_t >= 0 && out_valid && out_index == 6'(stall_t) && stall_cnt < stall_len) begin
            out_ready = 1'b0;
            if (stall_cnt == 0) snap_d = out_data;
            else if (out_data !== snap_d || out_index !== 6'(stall_t)) stall_moved++;
            if (hfnc_op !== 3'd0) stall_hf++;
            stall_cnt++;
            stall_seen++;
         end else begin
            out_ready = 1'b1;
         end
         if (out_valid && out_ready) begin
            got[n_got] = out_data;
            if (out_index !== 6'(n_got)) idx_bad++;
            if (out_last) begin
               last_cnt++;
               if (out_index != 6'd63) last_bad++;
            end
            hs_cyc[n_got] = cyc;
            n_got++;
            if (n_got == 64) in_valid = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      vectors += 7;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      if (out_data !== 32'd0) begin miscompares++; $display("FAIL rst_out_data: got %h want 0", out_data); end
      if (out_index !== 6'd0) begin miscompares++; $display("FAIL rst_out_index: got %0d want 0", out_index); end
      if (out_last !== 1'b0) begin miscompares++; $display("FAIL rst_out_last: got %b want 0", out_last); end
      if (hfnc_op !== 3'd0) begin miscompares++; $display("FAIL rst_hfnc_op: got %0d want 0", hfnc_op); end
      if (hfnc_x !== 32'd0) begin miscompares++; $display("FAIL rst_hfnc_x: got %h want 0", hfnc_x); end
   endtask

   task automatic check_words(input string tag);
      vectors++;
      if (n_got != 64) begin
         miscompares++;
         $display("FAIL %s_timeout: got %0d words want 64", tag, n_got);
      end
      for (int t = 0; t < n_got; t++) begin
         vectors++;
         if (got[t] !== exp_w[t]) begin
            miscompares++;
            $display("FAIL %s_W%0d: got %h want %h", tag, t, got[t], exp_w[t]);
         end
      end
   endtask

   task automatic test_abc();
      int span;
      for (int i = 0; i < 16; i++) msg[i] = 32'd0;
      msg[0]  = 32'h61626380;
      msg[15] = 32'h00000018;
      make_ref();
      load_block(1'b0);
      collect(-1, 0, 1'b0, -1);
      @(negedge clk);
      vectors += 8;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL abc_next_load: in_ready %b want 1", in_ready); end
      if (got[16] !== 32'h61626380) begin miscompares++; $display("FAIL abc_W16: got %h want 61626380", got[16]); end
      if (got[17] !== 32'h000F0000) begin miscompares++; $display("FAIL abc_W17: got %h want 000f0000", got[17]); end
      if (got[63] !== 32'h12B1EDEB) begin miscompares++; $display("FAIL abc_W63: got %h want 12b1edeb", got[63]); end
      if (last_cnt != 1 || last_bad != 0) begin
         miscompares++; $display("FAIL abc_last: count %0d bad %0d want 1/0", last_cnt, last_bad);
      end
      if (idx_bad != 0) begin miscompares++; $display("FAIL abc_index: %0d bad indices want 0", idx_bad); end
      span = hs_cyc[63] - rise_cyc[0] + 1;
      if (span != 16 + 48 * PER) begin
         miscompares++; $display("FAIL abc_cycles: got %0d want %0d", span, 16 + 48 * PER);
      end
      if (rise_cyc[0] != 1) begin miscompares++; $display("FAIL abc_first_valid: cycle %0d want 1", rise_cyc[0]); end
      check_words("abc");
   endtask

   task automatic test_protocol();
      int h;
      logic [2:0]  eop1, eop2;
      logic [31:0] ex1, ex2;
      rand_msg();
      load_block(1'b0);
      collect(-1, 0, 1'b0, -1);
      h    = hs_cyc[15];
      eop1 = EXT ? 3'd6 : 3'd0;
      eop2 = EXT ? 3'd7 : 3'd0;
      ex1  = EXT ? msg[1] : 32'd0;
      ex2  = EXT ? msg[14] : 32'd0;
      vectors += 4;
      if (op_tr[h+1] !== eop1 || x_tr[h+1] !== ex1) begin
         miscompares++; $display("FAIL probe_sig0: op %0d x %h want op %0d x %h", op_tr[h+1], x_tr[h+1], eop1, ex1);
      end
      if (op_tr[h+2] !== eop2 || x_tr[h+2] !== ex2) begin
         miscompares++; $display("FAIL probe_sig1: op %0d x %h want op %0d x %h", op_tr[h+2], x_tr[h+2], eop2, ex2);
      end
      if (op_tr[h+3] !== 3'd0) begin miscompares++; $display("FAIL probe_idle: op %0d want 0", op_tr[h+3]); end
      if (rise_cyc[16] != h + PER) begin
         miscompares++; $display("FAIL probe_t16_latency: cycle %0d want %0d", rise_cyc[16], h + PER);
      end
      check_words("probe");
   endtask

   task automatic test_backpressure();
      rand_msg();
      load_block(1'b0);
      collect(20, 5, 1'b0, -1);
      vectors += 4;
      if (stall_seen != 5 || stall_moved != 0) begin
         miscompares++; $display("FAIL bp_frozen: stalled %0d moved %0d want 5/0", stall_seen, stall_moved);
      end
      if (stall_hf != 0) begin miscompares++; $display("FAIL bp_hfnc_idle: %0d requests want 0", stall_hf); end
      if (hs_cyc[20] != rise_cyc[20] + 5) begin
         miscompares++; $display("FAIL bp_hold: handshake %0d want %0d", hs_cyc[20], rise_cyc[20] + 5);
      end
      if (rise_cyc[21] != hs_cyc[20] + PER) begin
         miscompares++; $display("FAIL bp_resume: cycle %0d want %0d", rise_cyc[21], hs_cyc[20] + PER);
      end
      check_words("bp");
   endtask

   task automatic test_back_to_back();
      for (int b = 0; b < 2; b++) begin
         rand_msg();
         load_block(1'b0);
         collect(-1, 0, 1'b1, -1);
         check_words(b == 0 ? "b2b0" : "b2b1");
         @(negedge clk);
         vectors++;
         if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_next_load: in_ready %b want 1", in_ready); end
      end
   endtask

   task automatic test_reset_mid();
      rand_msg();
      load_block(1'b0);
      collect(-1, 0, 1'b0, 40);
      #1 rst = 1'b1;
      #1;
      vectors += 2;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
      @(negedge clk);
      rst = 1'b0;
      rand_msg();
      load_block(1'b0);
      collect(-1, 0, 1'b0, -1);
      check_words("midrst");
   endtask

   task automatic test_gaps();
      rand_msg();
      load_block(1'b1);
      collect(-1, 0, 1'b0, -1);
      check_words("gaps");
      vectors++;
      if (last_cnt != 1 || last_bad != 0) begin
         miscompares++; $display("FAIL gaps_last: count %0d bad %0d want 1/0", last_cnt, last_bad);
      end
   endtask

   initial begin
      test_reset();
      test_abc();
      test_protocol();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_gaps();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
